// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// FSM state codes, opcode/funct values, ALU operation codes and datapath mux selects.
package multicycle_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StMemAdr = 4'd2,
      StMemRd  = 4'd3,
      StMemWb  = 4'd4,
      StMemWr  = 4'd5,
      StExec   = 4'd6,
      StAluWb  = 4'd7,
      StBranch = 4'd8,
      StAddiEx = 4'd9,
      StAddiWb = 4'd10,
      StJump   = 4'd11,
      StJal    = 4'd12,
      StJr     = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;
   localparam logic [5:0] FN_JR  = 6'b001000;

   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_SLT = 5'b00111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] REGDST_RT = 2'b00;
   localparam logic [1:0] REGDST_RD = 2'b01;
   localparam logic [1:0] REGDST_RA = 2'b10;

   localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
   localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
   localparam logic [1:0] MEMTOREG_PC     = 2'b10;

   localparam logic       SRCA_PC = 1'b0;
   localparam logic       SRCA_A  = 1'b1;

   localparam logic [1:0] SRCB_B      = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;
   localparam logic [1:0] PCSRC_REG    = 2'b11;

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle FSM (master) and the datapath (slave):
// IR fields and ALU zero flag in, every mux select and write enable out.
interface multicycle_control_if #(
   parameter int unsigned STATE_W = 4,
   parameter int unsigned ALU_W   = 5
) ();

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               zero;

   logic               pcWrite;
   logic               iOrD;
   logic               irWrite;
   logic               memWrite;
   logic               regWriteEnable;
   logic [1:0]         regDst;
   logic [1:0]         memToReg;
   logic               aluSrcA;
   logic [1:0]         aluSrcB;
   logic [1:0]         pcSrc;
   logic [ALU_W-1:0]   aluControl;
   logic [STATE_W-1:0] state;
   logic               illegalOp;

   modport master (
      input  opcode, funct, zero,
      output pcWrite, iOrD, irWrite, memWrite, regWriteEnable, regDst, memToReg,
             aluSrcA, aluSrcB, pcSrc, aluControl, state, illegalOp
   );

   modport slave (
      output opcode, funct, zero,
      input  pcWrite, iOrD, irWrite, memWrite, regWriteEnable, regDst, memToReg,
             aluSrcA, aluSrcB, pcSrc, aluControl, state, illegalOp
   );

endinterface

// File: rtl/alu_decoder.sv
// Maps the FSM's ALU request (add / sub / by-funct) onto the datapath ALU code and
// flags funct values that are not a supported ALU operation.
module alu_decoder
   import multicycle_pkg::*;
#(
   parameter int unsigned ALU_W = 5
) (
   input  logic [1:0]       alu_op,
   input  logic [5:0]       funct,
   output logic [ALU_W-1:0] alu_control,
   output logic             funct_illegal
);

   logic [4:0] funct_code;
   logic [4:0] code;

   // jr is not an ALU operation, so it reads as illegal here; the FSM checks it first.
   always_comb begin
      funct_code    = ALU_ADD;
      funct_illegal = 1'b0;
      case (funct)
         FN_ADD:  funct_code = ALU_ADD;
         FN_SUB:  funct_code = ALU_SUB;
         FN_AND:  funct_code = ALU_AND;
         FN_OR:   funct_code = ALU_OR;
         FN_SLT:  funct_code = ALU_SLT;
         default: funct_illegal = 1'b1;
      endcase
   end

   always_comb begin
      case (alu_op)
         ALUOP_SUB:   code = ALU_SUB;
         ALUOP_FUNCT: code = funct_code;
         default:     code = ALU_ADD;
      endcase
   end

   assign alu_control = ALU_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath; pcWrite in BRANCH is the only
// output that also depends on the ALU zero flag.
module multicycle_control
   import multicycle_pkg::*;
#(
   parameter int unsigned STATE_W = 4,
   parameter int unsigned ALU_W   = 5
) (
   input logic                 clock,
   input logic                 reset,
   multicycle_control_if.master bus
);

   logic [3:0]       state_q;
   logic [3:0]       state_d;
   logic [1:0]       alu_op;
   logic             alu_en;
   logic [ALU_W-1:0] alu_ctrl;
   logic             funct_bad;

   alu_decoder #(
      .ALU_W(ALU_W)
   ) u_alu_decoder (
      .alu_op       (alu_op),
      .funct        (bus.funct),
      .alu_control  (alu_ctrl),
      .funct_illegal(funct_bad)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StFetch;
      end else begin
         state_q <= state_d;
      end
   end

   // ALU request per state; states that leave the ALU idle drive code 0.
   always_comb begin
      alu_op = ALUOP_ADD;
      alu_en = 1'b0;
      case (state_q)
         StDecode, StMemAdr, StAddiEx: alu_en = 1'b1;
         StExec: begin
            alu_en = 1'b1;
            alu_op = ALUOP_FUNCT;
         end
         StBranch: begin
            alu_en = 1'b1;
            alu_op = ALUOP_SUB;
         end
         StMemRd, StMemWb, StMemWr, StAluWb, StAddiWb, StJump, StJal, StJr: alu_en = 1'b0;
         default: alu_en = 1'b1;
      endcase
   end

   assign bus.aluControl = (reset || !alu_en) ? '0 : alu_ctrl;
   assign bus.state      = STATE_W'(state_q);

   always_comb begin
      state_d            = StFetch;
      bus.pcWrite        = 1'b0;
      bus.iOrD           = 1'b0;
      bus.irWrite        = 1'b0;
      bus.memWrite       = 1'b0;
      bus.regWriteEnable = 1'b0;
      bus.regDst         = REGDST_RT;
      bus.memToReg       = MEMTOREG_ALUOUT;
      bus.aluSrcA        = SRCA_PC;
      bus.aluSrcB        = SRCB_B;
      bus.pcSrc          = PCSRC_ALU;
      bus.illegalOp      = 1'b0;

      case (state_q)
         StDecode: begin
            // ALUOut captures the branch target while the opcode is decoded.
            bus.aluSrcA = SRCA_PC;
            bus.aluSrcB = SRCB_IMM_SH;
            case (bus.opcode)
               OP_LW, OP_SW:   state_d = StMemAdr;
               OP_BEQ, OP_BNE: state_d = StBranch;
               OP_ADDI:        state_d = StAddiEx;
               OP_J:           state_d = StJump;
               OP_JAL:         state_d = StJal;
               OP_RTYPE: begin
                  if (bus.funct == FN_JR) begin
                     state_d = StJr;
                  end else if (funct_bad) begin
                     bus.illegalOp = 1'b1;
                  end else begin
                     state_d = StExec;
                  end
               end
               default: bus.illegalOp = 1'b1;
            endcase
         end
         StMemAdr: begin
            bus.aluSrcA = SRCA_A;
            bus.aluSrcB = SRCB_IMM;
            state_d     = (bus.opcode == OP_SW) ? StMemWr : StMemRd;
         end
         StMemRd: begin
            bus.iOrD = 1'b1;
            state_d  = StMemWb;
         end
         StMemWb: begin
            bus.regDst         = REGDST_RT;
            bus.memToReg       = MEMTOREG_MDR;
            bus.regWriteEnable = 1'b1;
         end
         StMemWr: begin
            bus.iOrD     = 1'b1;
            bus.memWrite = 1'b1;
         end
         StExec: begin
            bus.aluSrcA = SRCA_A;
            bus.aluSrcB = SRCB_B;
            state_d     = StAluWb;
         end
         StAluWb: begin
            bus.regDst         = REGDST_RD;
            bus.memToReg       = MEMTOREG_ALUOUT;
            bus.regWriteEnable = 1'b1;
         end
         StBranch: begin
            bus.aluSrcA = SRCA_A;
            bus.aluSrcB = SRCB_B;
            bus.pcSrc   = PCSRC_ALUOUT;
            bus.pcWrite = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
         end
         StAddiEx: begin
            bus.aluSrcA = SRCA_A;
            bus.aluSrcB = SRCB_IMM;
            state_d     = StAddiWb;
         end
         StAddiWb: begin
            bus.regDst         = REGDST_RT;
            bus.memToReg       = MEMTOREG_ALUOUT;
            bus.regWriteEnable = 1'b1;
         end
         StJump: begin
            bus.pcSrc   = PCSRC_JUMP;
            bus.pcWrite = 1'b1;
         end
         StJal: begin
            // PC already holds PC+4 from FETCH, so it is the link value.
            bus.pcSrc          = PCSRC_JUMP;
            bus.pcWrite        = 1'b1;
            bus.regDst         = REGDST_RA;
            bus.memToReg       = MEMTOREG_PC;
            bus.regWriteEnable = 1'b1;
         end
         StJr: begin
            bus.pcSrc   = PCSRC_REG;
            bus.pcWrite = 1'b1;
         end
         default: begin
            // FETCH, and unused encodings behave exactly like FETCH.
            bus.iOrD    = 1'b0;
            bus.irWrite = 1'b1;
            bus.aluSrcA = SRCA_PC;
            bus.aluSrcB = SRCB_FOUR;
            bus.pcSrc   = PCSRC_ALU;
            bus.pcWrite = 1'b1;
            state_d     = StDecode;
         end
      endcase

      // Reset aborts any in-flight instruction without a write in that cycle.
      if (reset) begin
         bus.pcWrite        = 1'b0;
         bus.iOrD           = 1'b0;
         bus.irWrite        = 1'b0;
         bus.memWrite       = 1'b0;
         bus.regWriteEnable = 1'b0;
         bus.regDst         = '0;
         bus.memToReg       = '0;
         bus.aluSrcA        = 1'b0;
         bus.aluSrcB        = '0;
         bus.pcSrc          = '0;
         bus.illegalOp      = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench: per-instruction expected cycle sequences built from the ISA rules,
// directed cases first, then random instructions with random zero flag.
module tb_multicycle_control;
   import multicycle_pkg::*;

   localparam int NUM_DIR   = 14;
   localparam int NUM_INSTR = NUM_DIR + 320;

   localparam int K_LW = 0, K_SW = 1, K_ALU = 2, K_JR = 3, K_BEQ = 4, K_BNE = 5;
   localparam int K_ADDI = 6, K_J = 7, K_JAL = 8, K_BAD = 9;

   typedef struct packed {
      logic       pc_write;
      logic       iord;
      logic       ir_write;
      logic       mem_write;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] mem_to_reg;
      logic       src_a;
      logic [1:0] src_b;
      logic [1:0] pc_src;
      logic [4:0] alu;
      logic       illegal;
   } outs_t;

   typedef struct {
      outs_t      o;
      int         pcw_mode;   // 0 fixed, 1 = zero, 2 = ~zero
      bit         chk_state;
      logic [3:0] st;
      bit         first;
      int         prev_lat;
      string      name;
   } exp_t;

   logic  clock = 1'b0;
   logic  reset;
   exp_t  exp_q[$];
   int    n_checks = 0;
   int    n_err = 0;
   int    last_lat = 0;
   int    run_len = 0;

   always #5 clock = ~clock;

   multicycle_control_if #(.STATE_W(4), .ALU_W(5)) bus ();

   multicycle_control #(
      .STATE_W(4),
      .ALU_W  (5)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   // Directed program: lw, add, sub, beq z1/z0, bne z1/z0, jal, jr, 111111, sw, addi, j, add+reset.
   logic [5:0] d_op [NUM_DIR] = '{6'b100011, 6'b000000, 6'b000000, 6'b000100, 6'b000100,
                                  6'b000101, 6'b000101, 6'b000011, 6'b000000, 6'b111111,
                                  6'b101011, 6'b001000, 6'b000010, 6'b000000};
   logic [5:0] d_fn [NUM_DIR] = '{6'b000111, 6'b100000, 6'b100010, 6'b100000, 6'b100000,
                                  6'b000000, 6'b000000, 6'b101010, 6'b001000, 6'b100000,
                                  6'b000000, 6'b001000, 6'b111111, 6'b100000};
   int         d_z  [NUM_DIR] = '{0, 0, 0, 1, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0};
   bit         d_ab [NUM_DIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

   function automatic bit alu_funct(input logic [5:0] fn);
      return fn == 6'b100000 || fn == 6'b100010 || fn == 6'b100100 ||
             fn == 6'b100101 || fn == 6'b101010;
   endfunction

   function automatic logic [4:0] alu_of(input logic [5:0] fn);
      case (fn)
         6'b100000: return 5'b00010;
         6'b100010: return 5'b00110;
         6'b100100: return 5'b00000;
         6'b100101: return 5'b00001;
         6'b101010: return 5'b00111;
         default:   return 5'b00000;
      endcase
   endfunction

   function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
      case (op)
         6'b100011: return K_LW;
         6'b101011: return K_SW;
         6'b000100: return K_BEQ;
         6'b000101: return K_BNE;
         6'b001000: return K_ADDI;
         6'b000010: return K_J;
         6'b000011: return K_JAL;
         6'b000000: begin
            if (fn == 6'b001000) return K_JR;
            if (alu_funct(fn)) return K_ALU;
            return K_BAD;
         end
         default: return K_BAD;
      endcase
   endfunction

   // FETCH-to-FETCH cycle counts of each instruction class.
   function automatic int lat_of(input int k);
      case (k)
         K_LW:                    return 5;
         K_SW, K_ALU, K_ADDI:     return 4;
         K_BEQ, K_BNE, K_J, K_JAL, K_JR: return 3;
         default:                 return 2;
      endcase
   endfunction

   function automatic string kname(input int k);
      case (k)
         K_LW: return "lw";     K_SW: return "sw";   K_ALU: return "alu";
         K_JR: return "jr";     K_BEQ: return "beq"; K_BNE: return "bne";
         K_ADDI: return "addi"; K_J: return "j";     K_JAL: return "jal";
         default: return "illegal";
      endcase
   endfunction

   function automatic exp_t blank(input string name, input logic [3:0] st);
      exp_t e;
      e.o         = '0;
      e.pcw_mode  = 0;
      e.chk_state = 1'b1;
      e.st        = st;
      e.first     = 1'b0;
      e.prev_lat  = 0;
      e.name      = name;
      return e;
   endfunction

   function automatic exp_t rst_rec(input bit chk);
      exp_t e;
      e = blank("reset", StFetch);
      e.chk_state = chk;
      return e;
   endfunction

   task automatic push_instr(input logic [5:0] op, input logic [5:0] fn);
      int    k;
      string n;
      exp_t  e;
      k = classify(op, fn);
      n = kname(k);
      e = blank({n, "/fetch"}, StFetch);
      e.first = 1'b1;  e.prev_lat = last_lat;
      e.o.ir_write = 1'b1;  e.o.pc_write = 1'b1;  e.o.src_b = 2'b01;  e.o.alu = 5'b00010;
      exp_q.push_back(e);
      e = blank({n, "/decode"}, StDecode);
      e.o.src_b = 2'b11;  e.o.alu = 5'b00010;  e.o.illegal = (k == K_BAD);
      exp_q.push_back(e);
      if (k == K_LW || k == K_SW) begin
         e = blank({n, "/memadr"}, StMemAdr);
         e.o.src_a = 1'b1;  e.o.src_b = 2'b10;  e.o.alu = 5'b00010;
         exp_q.push_back(e);
      end
      case (k)
         K_LW: begin
            e = blank({n, "/memrd"}, StMemRd);  e.o.iord = 1'b1;  exp_q.push_back(e);
            e = blank({n, "/memwb"}, StMemWb);
            e.o.reg_we = 1'b1;  e.o.mem_to_reg = 2'b01;  exp_q.push_back(e);
         end
         K_SW: begin
            e = blank({n, "/memwr"}, StMemWr);
            e.o.iord = 1'b1;  e.o.mem_write = 1'b1;  exp_q.push_back(e);
         end
         K_ALU: begin
            e = blank({n, "/exec"}, StExec);
            e.o.src_a = 1'b1;  e.o.alu = alu_of(fn);  exp_q.push_back(e);
            e = blank({n, "/aluwb"}, StAluWb);
            e.o.reg_we = 1'b1;  e.o.reg_dst = 2'b01;  exp_q.push_back(e);
         end
         K_BEQ, K_BNE: begin
            e = blank({n, "/branch"}, StBranch);
            e.o.src_a = 1'b1;  e.o.alu = 5'b00110;  e.o.pc_src = 2'b01;
            e.pcw_mode = (k == K_BEQ) ? 1 : 2;
            exp_q.push_back(e);
         end
         K_ADDI: begin
            e = blank({n, "/addiex"}, StAddiEx);
            e.o.src_a = 1'b1;  e.o.src_b = 2'b10;  e.o.alu = 5'b00010;  exp_q.push_back(e);
            e = blank({n, "/addiwb"}, StAddiWb);  e.o.reg_we = 1'b1;  exp_q.push_back(e);
         end
         K_J: begin
            e = blank({n, "/jump"}, StJump);
            e.o.pc_src = 2'b10;  e.o.pc_write = 1'b1;  exp_q.push_back(e);
         end
         K_JAL: begin
            e = blank({n, "/jal"}, StJal);
            e.o.pc_src = 2'b10;  e.o.pc_write = 1'b1;  e.o.reg_dst = 2'b10;
            e.o.mem_to_reg = 2'b10;  e.o.reg_we = 1'b1;  exp_q.push_back(e);
         end
         K_JR: begin
            e = blank({n, "/jr"}, StJr);
            e.o.pc_src = 2'b11;  e.o.pc_write = 1'b1;  exp_q.push_back(e);
         end
         default: ;
      endcase
      last_lat = lat_of(k);
   endtask

   task automatic rand_instr(output logic [5:0] op, output logic [5:0] fn);
      int r;
      r  = $urandom_range(0, 11);
      fn = 6'($urandom_range(0, 63));
      case (r)
         0: op = 6'b100011;
         1: op = 6'b101011;
         2, 3: begin
            op = 6'b000000;
            case ($urandom_range(0, 4))
               0: fn = 6'b100000;
               1: fn = 6'b100010;
               2: fn = 6'b100100;
               3: fn = 6'b100101;
               default: fn = 6'b101010;
            endcase
         end
         4: begin op = 6'b000000;  fn = 6'b001000; end
         5: op = 6'b000100;
         6: op = 6'b000101;
         7: op = 6'b001000;
         8: op = 6'b000010;
         9: op = 6'b000011;
         10: begin
            op = 6'($urandom_range(0, 63));
            while (classify(op, 6'b100000) != K_BAD) op = 6'($urandom_range(0, 63));
         end
         default: begin
            op = 6'b000000;
            while (classify(op, fn) != K_BAD) fn = 6'($urandom_range(0, 63));
         end
      endcase
   endtask

   // Compare process: one expected record per cycle, sampled mid-cycle.
   always @(negedge clock) begin
      exp_t  e;
      outs_t act;
      outs_t want;
      if (exp_q.size() == 0) begin
         n_checks++;
         n_err++;
         $display("FAIL model_empty: got no expectation want one per cycle");
      end else begin
         e    = exp_q.pop_front();
         want = e.o;
         if (e.pcw_mode == 1) want.pc_write = bus.zero;
         if (e.pcw_mode == 2) want.pc_write = ~bus.zero;
         act = {bus.pcWrite, bus.iOrD, bus.irWrite, bus.memWrite, bus.regWriteEnable,
                bus.regDst, bus.memToReg, bus.aluSrcA, bus.aluSrcB, bus.pcSrc,
                bus.aluControl, bus.illegalOp};
         n_checks++;
         if (act !== want) begin
            n_err++;
            $display("FAIL %s outputs: got %05h want %05h (zero=%0b)", e.name, act, want,
                     bus.zero);
         end
         if (e.chk_state) begin
            n_checks++;
            if (bus.state !== e.st) begin
               n_err++;
               $display("FAIL %s state: got %0d want %0d", e.name, bus.state, e.st);
            end
         end
         if (!reset) begin
            if (bus.state == StFetch) begin
               if (e.first && e.prev_lat != 0) begin
                  n_checks++;
                  if (run_len != e.prev_lat) begin
                     n_err++;
                     $display("FAIL latency before %s: got %0d cycles want %0d", e.name,
                              run_len, e.prev_lat);
                  end
               end
               run_len = 1;
            end else begin
               run_len++;
            end
         end
      end
   end

   initial begin
      int         idx;
      int         rst_left;
      int         issued;
      int         zmode;
      bit         abort;
      logic [5:0] op;
      logic [5:0] fn;
      reset      = 1'b1;
      bus.opcode = '0;
      bus.funct  = '0;
      bus.zero   = 1'b0;
      rst_left   = 2;
      idx        = 0;
      issued     = 0;
      zmode      = 0;
      abort      = 1'b0;
      for (int cyc = 0; cyc < 20000 && issued < NUM_INSTR; cyc++) begin
         @(posedge clock);
         #1;
         bus.zero = (zmode == 0) ? 1'($urandom_range(0, 1)) : (zmode == 1);
         if (rst_left > 0) begin
            reset = 1'b1;
            exp_q.push_back(rst_rec(1'b1));
            rst_left--;
            idx = 0;
         end else begin
            reset = 1'b0;
            idx++;
            if (abort && idx == 2) begin
               // Reset lands while the DUT is in EXEC; ALUWB must never happen.
               abort    = 1'b0;
               reset    = 1'b1;
               exp_q.delete();
               exp_q.push_back(rst_rec(1'b0));
               rst_left = 2;
               last_lat = 0;
            end else if (exp_q.size() == 0) begin
               if (issued < NUM_DIR) begin
                  op    = d_op[issued];
                  fn    = d_fn[issued];
                  zmode = d_z[issued];
                  abort = d_ab[issued];
               end else begin
                  rand_instr(op, fn);
                  zmode = 0;
               end
               bus.opcode = op;
               bus.funct  = fn;
               push_instr(op, fn);
               issued++;
               idx = 0;
            end
         end
      end
      if (issued < NUM_INSTR) begin
         n_checks++;
         n_err++;
         $display("FAIL cycle_budget: got %0d instructions want %0d", issued, NUM_INSTR);
      end
      @(negedge clock);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
